// File: rtl/blink_period_meter.sv
// Measures period and high time of an external square wave on BLINK, in OSCIN cycles,
// and flags loss of signal. Optional deglitch filter selected by macro DEGLITCH_EN.
module blink_period_meter #(
    parameter int CNT_W    = 28,
    parameter int TIMEOUT  = 134217728,
    parameter int FILT_CYC = 4
) (
    input  logic             OSCIN,
    input  logic             RSTN,
    input  logic             BLINK,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_CYC,
    output logic             VALID,
    output logic             ACTIVE,
    output logic             LOST,
    output logic             LED
);

    if ((TIMEOUT < 2) || (longint'(TIMEOUT) >= (longint'(1) << CNT_W)) || (FILT_CYC < 1)) begin : g_bad_cfg
        $error("blink_period_meter: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W, FILT_CYC >= 1");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic             sync1_r;
    logic             sync2_r;
    logic             lvl_s;
    logic             lvl_d_r;
    logic             rise_s;
    logic             fall_s;
    logic             timeout_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hhold_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic             fall_seen_r;
    logic             valid_r;
    logic             active_r;
    logic             lost_r;

    // Two-flop synchronizer for the asynchronous pin, then the delayed copy for edge detection
    always_ff @(posedge OSCIN or negedge RSTN) begin
        if (!RSTN) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            lvl_d_r <= 1'b0;
        end else begin
            sync1_r <= BLINK;
            sync2_r <= sync1_r;
            lvl_d_r <= lvl_s;
        end
    end

`ifdef DEGLITCH_EN
    localparam int FW = $clog2(FILT_CYC + 1);

    logic [FW-1:0] fcnt_r;
    logic          filt_r;

    // Filtered level follows the synchronized input only after FILT_CYC consecutive disagreeing cycles
    always_ff @(posedge OSCIN or negedge RSTN) begin
        if (!RSTN) begin
            fcnt_r <= {FW{1'b0}};
            filt_r <= 1'b0;
        end else if (sync2_r != filt_r) begin
            if (fcnt_r == FW'(FILT_CYC - 1)) begin
                fcnt_r <= {FW{1'b0}};
                filt_r <= sync2_r;
            end else begin
                fcnt_r <= fcnt_r + {{(FW-1){1'b0}}, 1'b1};
            end
        end else begin
            fcnt_r <= {FW{1'b0}};
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = sync2_r;
`endif

    assign rise_s    = lvl_s & ~lvl_d_r;
    assign fall_s    = ~lvl_s & lvl_d_r;
    assign timeout_s = (state_r == MEASURE) && (cnt_r == TIMEOUT_V);

    // State register
    always_ff @(posedge OSCIN or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next state: a rise always keeps or enters MEASURE, so it beats a same-cycle timeout
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt = MEASURE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    state_nxt = MEASURE;
                end else if (timeout_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = MEASURE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Period/high-time counters and registered results
    always_ff @(posedge OSCIN or negedge RSTN) begin
        if (!RSTN) begin
            cnt_r       <= CNT_ZERO;
            hcnt_r      <= CNT_ZERO;
            hhold_r     <= CNT_ZERO;
            period_r    <= CNT_ZERO;
            high_r      <= CNT_ZERO;
            fall_seen_r <= 1'b0;
            valid_r     <= 1'b0;
            active_r    <= 1'b0;
            lost_r      <= 1'b0;
        end else begin
            valid_r  <= 1'b0;
            active_r <= (state_nxt == MEASURE);
            if (state_r == IDLE) begin
                fall_seen_r <= 1'b0;
                if (rise_s) begin
                    cnt_r  <= CNT_ONE;
                    hcnt_r <= CNT_ONE;
                end else begin
                    cnt_r  <= CNT_ZERO;
                    hcnt_r <= CNT_ZERO;
                end
            end else if (rise_s) begin
                period_r    <= cnt_r;
                // No fall since the last rise means the whole period looked high
                high_r      <= fall_seen_r ? hhold_r : cnt_r;
                valid_r     <= 1'b1;
                lost_r      <= 1'b0;
                cnt_r       <= CNT_ONE;
                hcnt_r      <= CNT_ONE;
                fall_seen_r <= 1'b0;
            end else if (timeout_s) begin
                lost_r      <= 1'b1;
                cnt_r       <= CNT_ZERO;
                hcnt_r      <= CNT_ZERO;
                fall_seen_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
                if (fall_s) begin
                    hhold_r     <= hcnt_r;
                    fall_seen_r <= 1'b1;
                end else if (lvl_d_r) begin
                    hcnt_r <= hcnt_r + CNT_ONE;
                end else begin
                    hcnt_r <= hcnt_r;
                end
            end
        end
    end

    assign PERIOD   = period_r;
    assign HIGH_CYC = high_r;
    assign VALID    = valid_r;
    assign ACTIVE   = active_r;
    assign LOST     = lost_r;
    assign LED      = lvl_d_r;

endmodule

// File: tb/tb_blink_period_meter.sv
// Self-checking bench for blink_period_meter: pin waveform built from high/low segments,
// expected results derived from pin rise times and segment lengths.
module tb_blink_period_meter;

    localparam int CNT_W   = 28;
    localparam int TIMEOUT = 5000;
    localparam int FILT    = 4;
`ifdef DEGLITCH_EN
    localparam int LAT    = 3 + FILT;
    localparam int MINSEG = FILT;
`else
    localparam int LAT    = 3;
    localparam int MINSEG = 1;
`endif

    logic             OSCIN;
    logic             RSTN;
    logic             BLINK;
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH_CYC;
    logic             VALID;
    logic             ACTIVE;
    logic             LOST;
    logic             LED;

    blink_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .FILT_CYC(FILT)
    ) dut (
        .OSCIN   (OSCIN),
        .RSTN    (RSTN),
        .BLINK   (BLINK),
        .PERIOD  (PERIOD),
        .HIGH_CYC(HIGH_CYC),
        .VALID   (VALID),
        .ACTIVE  (ACTIVE),
        .LOST    (LOST),
        .LED     (LED)
    );

    typedef struct {
        int cyc;
        bit tmo;
    } ev_t;

    typedef struct {
        int due;
        int per;
        int hi;
    } exp_t;

    ev_t         evq[$];
    exp_t        vq[$];
    int          cyc;
    int          errors;
    int          checks;
    logic [15:0] hist;
    int          prev_t;
    int          prev_high;
    bit          have_prev;
    logic        exp_active;
    logic        exp_lost;
    int          exp_period;
    int          exp_high;

    initial begin
        OSCIN = 1'b0;
        forever #5 OSCIN = ~OSCIN;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        vq.delete();
        evq.delete();
        have_prev  = 1'b0;
        prev_t     = 0;
        prev_high  = 0;
        exp_active = 1'b0;
        exp_lost   = 1'b0;
        exp_period = 0;
        exp_high   = 0;
    endtask

    // A visible pin rise at cycle t followed by n high cycles
    task automatic model_rise(input int t, input int n);
        if (have_prev && (t - prev_t) <= TIMEOUT) begin
            vq.push_back('{t + LAT, t - prev_t, prev_high});
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].tmo) evq.delete(i);
            end
        end
        evq.push_back('{t + LAT, 1'b0});
        evq.push_back('{t + LAT + TIMEOUT, 1'b1});
        have_prev = 1'b1;
        prev_t    = t;
        prev_high = n;
    endtask

    task automatic step();
        int   i;
        logic exp_v;
        @(posedge OSCIN);
        #1;
        cyc++;
        hist = {hist[14:0], BLINK};
        if (!RSTN) begin
            chk("reset_outputs", 64'({PERIOD, HIGH_CYC, VALID, ACTIVE, LOST, LED}), 64'd0);
        end else begin
            i = 0;
            while (i < evq.size()) begin
                if (evq[i].cyc == cyc) begin
                    if (evq[i].tmo) begin
                        exp_active = 1'b0;
                        exp_lost   = 1'b1;
                    end else begin
                        exp_active = 1'b1;
                    end
                    evq.delete(i);
                end else begin
                    i++;
                end
            end
            exp_v = (vq.size() > 0) && (vq[0].due == cyc);
            if (exp_v) begin
                exp_period = vq[0].per;
                exp_high   = vq[0].hi;
                exp_lost   = 1'b0;
                void'(vq.pop_front());
            end
            chk("valid", 64'(VALID), 64'(exp_v));
            chk("period", 64'(PERIOD), 64'(exp_period));
            chk("high_cyc", 64'(HIGH_CYC), 64'(exp_high));
            chk("active", 64'(ACTIVE), 64'(exp_active));
            chk("lost", 64'(LOST), 64'(exp_lost));
`ifdef DEGLITCH_EN
            if (hist[FILT+5:0] == '0 || hist[FILT+5:0] == '1) chk("led", 64'(LED), 64'(hist[0]));
`else
            chk("led", 64'(LED), 64'(hist[2]));
`endif
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        if (lvl && !BLINK && n >= MINSEG) model_rise(cyc, n);
        BLINK = lvl;
        repeat (n) step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        hist   = 16'h0000;
        RSTN   = 1'b0;
        BLINK  = 1'b0;
        model_reset();
        #1;
        chk("reset_state", 64'({PERIOD, HIGH_CYC, VALID, ACTIVE, LOST, LED}), 64'd0);
        repeat (3) step();
        RSTN = 1'b1;

        // 1000-cycle period, 50% duty
        seg(1'b0, 100);
        repeat (5) begin
            seg(1'b1, 500);
            seg(1'b0, 500);
        end
        // Duty change, then period change to 777
        repeat (3) begin
            seg(1'b1, 250);
            seg(1'b0, 750);
        end
        repeat (4) begin
            seg(1'b1, 300);
            seg(1'b0, 477);
        end
        // Random periods and duty cycles
        repeat (20) begin
            seg(1'b1, int'($urandom_range(20, 400)));
            seg(1'b0, int'($urandom_range(20, 400)));
        end
        // Loss of signal, then restart
        seg(1'b1, 500);
        seg(1'b0, 500);
        seg(1'b1, 500);
        seg(1'b0, 6000);
        repeat (2) begin
            seg(1'b1, 500);
            seg(1'b0, 500);
        end
        // Period exactly TIMEOUT survives, one cycle longer times out
        repeat (3) begin
            seg(1'b1, 2500);
            seg(1'b0, 2500);
        end
        seg(1'b1, 2500);
        seg(1'b0, 2501);
        repeat (2) begin
            seg(1'b1, 500);
            seg(1'b0, 500);
        end
        // Short glitch inside a low phase
        seg(1'b1, 500);
        seg(1'b0, 300);
        seg(1'b1, 2);
        seg(1'b0, 698);
        repeat (2) begin
            seg(1'b1, 500);
            seg(1'b0, 500);
        end
        // Asynchronous reset in the middle of a period
        seg(1'b1, 500);
        seg(1'b0, 200);
        #3;
        RSTN = 1'b0;
        #1;
        chk("async_reset", 64'({PERIOD, HIGH_CYC, VALID, ACTIVE, LOST, LED}), 64'd0);
        repeat (3) step();
        RSTN = 1'b1;
        model_reset();
        seg(1'b0, 100);
        repeat (3) begin
            seg(1'b1, 400);
            seg(1'b0, 600);
        end
        seg(1'b0, 20);
        chk("pending_valid", 64'(vq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
Receive end of the board's LED blink signal: samples an external square wave on pin BLINK in the OSCIN domain and measures it. Reports period and high time in OSCIN cycles. Flags loss of signal. Used to check a blinky divider on a second board, or looped back from our own LED pin, with results driving a debug LED and status readout.

Parameters:
CNT_W, 28, width of period/high-time counters and outputs (2^28 cycles ≈ 2.68 s at 100 MHz).
TIMEOUT, 134217728, cycles without a detected rising edge before LOST; must satisfy 2 <= TIMEOUT < 2^CNT_W.
FILT_CYC, 4, stability length in cycles for the deglitch filter (used only with DEGLITCH_EN).

Ports:
OSCIN  input  1  system clock, 100 MHz, all logic on posedge.
RSTN  input  1  asynchronous active-low reset.
BLINK  input  1  asynchronous square wave under measurement.
PERIOD  output  CNT_W  cycles between the last two accepted rising edges.
HIGH_CYC  output  CNT_W  high-phase cycles within that period.
VALID  output  1  one-cycle strobe when PERIOD/HIGH_CYC update.
ACTIVE  output  1  high while in MEASURE state.
LOST  output  1  sticky timeout flag; cleared by the next VALID.
LED  output  1  synchronized (filtered) BLINK level, for visual echo.

Behaviour:
- Reset (RSTN=0, async): all flops 0. PERIOD=0, HIGH_CYC=0, VALID=0, ACTIVE=0, LOST=0, LED=0, state=IDLE. RSTN is released synchronously by the board; no internal reset synchronizer.
- Input path: 2-flop synchronizer, then a registered copy for edge detection. rise = s & ~s_d; fall = ~s & s_d. Pin-to-rise latency is 3 OSCIN cycles, fixed. LED = s_d.
- Counter cnt (CNT_W bits):
  - On an accepted rise, cnt <= 1.
  - Otherwise, in MEASURE, cnt <= cnt+1.
  - In IDLE, cnt holds 0.
  - With edges detected at cycles t0 and t1, the measured period is exactly t1-t0.
- High counter hcnt:
  - Loads 1 on rise and increments while s_d=1.
  - On fall, hcnt is copied to hold register hhold.
  - If no fall occurs between two rises, hhold = full period. Duty 100% is impossible to sample, so this marks a filter/glitch artefact.
- States:
  - IDLE: a rise loads cnt and moves to MEASURE. Falls are ignored. No VALID on the first edge.
  - MEASURE, rise: PERIOD <= cnt; HIGH_CYC <= hhold (or hcnt if fall coincides, see below); VALID=1 for that one cycle (registered, visible next cycle); LOST <= 0; cnt <= 1; stay in MEASURE.
  - MEASURE, cnt == TIMEOUT and no rise: go to IDLE, LOST <= 1, cnt <= 0. PERIOD and HIGH_CYC hold their last values.
- ACTIVE = (state == MEASURE), registered.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins. PERIOD=TIMEOUT, VALID, stay in MEASURE.
  - rise and fall in the same cycle: impossible after the edge detector, since both cannot assert together.
- No wrap: cnt never exceeds TIMEOUT because the TIMEOUT < 2^CNT_W rule guarantees it. Implementation asserts this at elaboration.
- Reset mid-measurement discards partial counts. The first VALID after reset needs two accepted rises.

Optional Feature:
DEGLITCH_EN
- Defined: between the synchronizer and the edge detector, a filtered level f changes only after the synchronized input has differed from f for FILT_CYC consecutive cycles. Edge detection and LED use f. Pin-to-rise latency becomes 3+FILT_CYC cycles. Pulses shorter than FILT_CYC cycles are invisible.
- Undefined: no filter; latency 3 cycles; every synchronized transition counts. FILT_CYC is unused.

Test Plan:
- Square wave, period 1000, high 500: after the second rise, VALID pulses once (3 cycles after the pin edge). PERIOD=1000, HIGH_CYC=500, ACTIVE=1, LOST=0. Repeats each 1000 cycles.
- Duty change to high 250, period 1000: next VALID gives HIGH_CYC=250, PERIOD=1000. Period change to 777 gives PERIOD=777 on the first full new period.
- Timeout (TIMEOUT=5000): stop toggling after a valid measurement. Exactly 5000 cycles after the last rise: ACTIVE=0, LOST=1, PERIOD holds 1000. Restart input: first rise gives no VALID; second rise gives VALID with LOST cleared.
- Rise landing exactly on cnt==TIMEOUT (TIMEOUT=5000, period 5000): VALID, PERIOD=5000, LOST stays 0, ACTIVE stays 1.
- 2-cycle glitch high inside a 1000-cycle low phase: with DEGLITCH_EN (FILT_CYC=4), ignored, PERIOD=1000. Without it, an extra VALID with a short PERIOD appears.
- Assert RSTN low mid-period: all outputs are 0 immediately (asynchronously). After release, the next VALID arrives only on the second rise.
